// File: rtl/tcp_tmp_rx_buf_rd_arb_if.sv
// tcp_tmp_rx_buf_rd_arb_if: requester-side and buffer-RAM-side read ports of the RX temp buffer read arbiter
interface tcp_tmp_rx_buf_rd_arb_if #(
  parameter int NUM_SRCS  = 2,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64,
  parameter int TAG_DEPTH = 4
);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
  logic [NUM_SRCS-1:0]        src_arb_rd_req_val;
  logic [NUM_SRCS*ADDR_W-1:0] src_arb_rd_req_addr;
  logic [NUM_SRCS-1:0]        arb_src_rd_req_rdy;
  logic [NUM_SRCS-1:0]        arb_src_rd_resp_val;
  logic [DATA_W-1:0]          arb_src_rd_resp_data;
  logic [NUM_SRCS-1:0]        src_arb_rd_resp_rdy;
  logic                       arb_buf_rd_req_val;
  logic [ADDR_W-1:0]          arb_buf_rd_req_addr;
  logic                       buf_arb_rd_req_rdy;
  logic                       buf_arb_rd_resp_val;
  logic [DATA_W-1:0]          buf_arb_rd_resp_data;
  logic                       arb_buf_rd_resp_rdy;
  logic [CNT_W-1:0]           arb_outstanding;
  modport master (
    input  src_arb_rd_req_val, src_arb_rd_req_addr, src_arb_rd_resp_rdy,
           buf_arb_rd_req_rdy, buf_arb_rd_resp_val, buf_arb_rd_resp_data,
    output arb_src_rd_req_rdy, arb_src_rd_resp_val, arb_src_rd_resp_data,
           arb_buf_rd_req_val, arb_buf_rd_req_addr, arb_buf_rd_resp_rdy, arb_outstanding
  );
  modport slave (
    output src_arb_rd_req_val, src_arb_rd_req_addr, src_arb_rd_resp_rdy,
           buf_arb_rd_req_rdy, buf_arb_rd_resp_val, buf_arb_rd_resp_data,
    input  arb_src_rd_req_rdy, arb_src_rd_resp_val, arb_src_rd_resp_data,
           arb_buf_rd_req_val, arb_buf_rd_req_addr, arb_buf_rd_resp_rdy, arb_outstanding
  );
endinterface

// File: rtl/tcp_tmp_rx_buf_rd_arb.sv
// tcp_tmp_rx_buf_rd_arb: round-robin sharing of the RX temp buffer read port with in-order response routing
module tcp_tmp_rx_buf_rd_arb #(
  parameter int NUM_SRCS  = 2,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64,
  parameter int TAG_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  tcp_tmp_rx_buf_rd_arb_if.master bus
);
  localparam int SRC_W = $clog2(NUM_SRCS);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  logic [SRC_W-1:0] r_rr_ptr;
  logic [SRC_W-1:0] r_tags [TAG_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [SRC_W-1:0] w_grant;
  logic [SRC_W-1:0] w_idx;
  logic [SRC_W-1:0] w_head;
  logic             w_any;
  logic             w_full;
  logic             w_empty;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_resp_rdy;
  // Descending scan so the candidate closest to rr_ptr is the last one written
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    for (int k = NUM_SRCS - 1; k >= 0; k--) begin
      w_idx = SRC_W'((int'(r_rr_ptr) + k) % NUM_SRCS);
      if (bus.src_arb_rd_req_val[w_idx]) begin
        w_grant = w_idx;
        w_any   = 1'b1;
      end
    end
  end
  // Full looks at the registered count only: a same-cycle pop does not free a slot
  assign w_full     = r_cnt == CNT_W'(TAG_DEPTH);
  assign w_empty    = r_cnt == '0;
  assign w_issue    = w_any & ~w_full;
  assign w_push     = w_issue & bus.buf_arb_rd_req_rdy;
  assign w_head     = r_tags[r_rd_ptr];
  assign w_resp_rdy = ~w_empty & bus.src_arb_rd_resp_rdy[w_head];
  assign w_pop      = bus.buf_arb_rd_resp_val & w_resp_rdy;
  assign bus.arb_buf_rd_req_val   = w_issue;
  assign bus.arb_buf_rd_req_addr  = w_issue ? bus.src_arb_rd_req_addr[int'(w_grant)*ADDR_W +: ADDR_W] : '0;
  assign bus.arb_src_rd_req_rdy   = w_push ? NUM_SRCS'(1'b1) << w_grant : '0;
  assign bus.arb_src_rd_resp_val  = (~w_empty & bus.buf_arb_rd_resp_val) ? NUM_SRCS'(1'b1) << w_head : '0;
  assign bus.arb_buf_rd_resp_rdy  = w_resp_rdy;
  assign bus.arb_src_rd_resp_data = bus.buf_arb_rd_resp_data;
  assign bus.arb_outstanding      = r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= (w_grant == SRC_W'(NUM_SRCS - 1)) ? '0 : w_grant + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_tags[r_wr_ptr] <= w_grant;
  end
  a_resp_needs_tag: assert property (@(posedge clk) disable iff (rst) !(bus.buf_arb_rd_resp_val && w_empty));
endmodule

// File: tb/tb_tcp_tmp_rx_buf_rd_arb.sv
// tb_tcp_tmp_rx_buf_rd_arb: directed stimulus with queued expected requests/responses checked by monitors
module tb_tcp_tmp_rx_buf_rd_arb;
  localparam int NS = 2, AW = 8, DW = 32, TD = 4;
  typedef struct packed {
    logic [NS-1:0] src;
    logic [DW-1:0] val;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t req_q[$];
  exp_t resp_q[$];
  always #5 clk = ~clk;
  tcp_tmp_rx_buf_rd_arb_if #(.NUM_SRCS(NS), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD)) bus ();
  tcp_tmp_rx_buf_rd_arb #(.NUM_SRCS(NS), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.arb_buf_rd_req_val && bus.buf_arb_rd_req_rdy) begin
      if (req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got addr %0h src_rdy %b expected no issue", bus.arb_buf_rd_req_addr, bus.arb_src_rd_req_rdy);
      end else begin
        e = req_q.pop_front();
        chk("req_src_rdy", 32'(bus.arb_src_rd_req_rdy), 32'(e.src));
        chk("req_addr", 32'(bus.arb_buf_rd_req_addr), e.val);
      end
    end
    if (bus.buf_arb_rd_resp_val && bus.arb_buf_rd_resp_rdy) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got val %b data %0h expected no accept", bus.arb_src_rd_resp_val, bus.arb_src_rd_resp_data);
      end else begin
        e = resp_q.pop_front();
        chk("resp_val", 32'(bus.arb_src_rd_resp_val), 32'(e.src));
        chk("resp_data", bus.arb_src_rd_resp_data, e.val);
      end
    end
  end
  initial begin
    bus.src_arb_rd_req_val   = '0;
    bus.src_arb_rd_req_addr  = '0;
    bus.src_arb_rd_resp_rdy  = 2'b11;
    bus.buf_arb_rd_req_rdy   = 1'b1;
    bus.buf_arb_rd_resp_val  = 1'b0;
    bus.buf_arb_rd_resp_data = '0;
    tick();
    tick();
    mid();
    chk("rst_outstanding", 32'(bus.arb_outstanding), 0);
    chk("rst_req_val", 32'(bus.arb_buf_rd_req_val), 0);
    chk("rst_resp_rdy", 32'(bus.arb_buf_rd_resp_rdy), 0);
    chk("rst_src_rdy", 32'(bus.arb_src_rd_req_rdy), 0);
    tick();
    // single read from source 0
    rst = 1'b0;
    bus.src_arb_rd_req_val  = 2'b01;
    bus.src_arb_rd_req_addr = {8'h00, 8'h10};
    req_q.push_back({2'b01, 32'h10});
    mid();
    chk("t1_out0", 32'(bus.arb_outstanding), 0);
    tick();
    bus.src_arb_rd_req_val   = 2'b00;
    bus.buf_arb_rd_resp_val  = 1'b1;
    bus.buf_arb_rd_resp_data = 32'hD0;
    resp_q.push_back({2'b01, 32'hD0});
    mid();
    chk("t1_out1", 32'(bus.arb_outstanding), 1);
    tick();
    bus.buf_arb_rd_resp_val = 1'b0;
    mid();
    chk("t1_out2", 32'(bus.arb_outstanding), 0);
    tick();
    // both sources continuous; rr_ptr is 1 so grants go 1,0,1,0
    bus.src_arb_rd_req_addr = {8'h21, 8'h20};
    for (int k = 0; k < 5; k++) begin
      bus.src_arb_rd_req_val   = (k < 4) ? 2'b11 : 2'b00;
      bus.buf_arb_rd_resp_val  = (k > 0);
      bus.buf_arb_rd_resp_data = 32'hA0 + 32'(k);
      if (k < 4) req_q.push_back({(k % 2 == 0) ? 2'b10 : 2'b01, (k % 2 == 0) ? 32'h21 : 32'h20});
      if (k > 0) resp_q.push_back({(k % 2 == 1) ? 2'b10 : 2'b01, 32'hA0 + 32'(k)});
      mid();
      chk("t2_out", 32'(bus.arb_outstanding), (k == 0) ? 0 : 1);
      tick();
    end
    // RAM stalls requests for 3 cycles, source 1 only
    bus.buf_arb_rd_resp_val = 1'b0;
    bus.buf_arb_rd_req_rdy  = 1'b0;
    bus.src_arb_rd_req_val  = 2'b10;
    bus.src_arb_rd_req_addr = {8'h33, 8'h30};
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("t3_req_val", 32'(bus.arb_buf_rd_req_val), 1);
      chk("t3_addr", 32'(bus.arb_buf_rd_req_addr), 32'h33);
      chk("t3_src_rdy", 32'(bus.arb_src_rd_req_rdy), 0);
      chk("t3_out", 32'(bus.arb_outstanding), 0);
      tick();
    end
    bus.buf_arb_rd_req_rdy = 1'b1;
    bus.src_arb_rd_req_val = 2'b11;
    req_q.push_back({2'b10, 32'h33});
    mid();
    tick();
    bus.src_arb_rd_req_val   = 2'b00;
    bus.buf_arb_rd_resp_val  = 1'b1;
    bus.buf_arb_rd_resp_data = 32'h5A;
    resp_q.push_back({2'b10, 32'h5A});
    mid();
    tick();
    // fill the tag FIFO with no responses
    bus.buf_arb_rd_resp_val = 1'b0;
    bus.src_arb_rd_req_val  = 2'b01;
    bus.src_arb_rd_req_addr = {8'h00, 8'h40};
    for (int k = 0; k < 4; k++) begin
      req_q.push_back({2'b01, 32'h40});
      mid();
      chk("t4_fill_out", 32'(bus.arb_outstanding), 32'(k));
      tick();
    end
    mid();
    chk("t4_full_src_rdy", 32'(bus.arb_src_rd_req_rdy), 0);
    chk("t4_full_req_val", 32'(bus.arb_buf_rd_req_val), 0);
    chk("t4_full_out", 32'(bus.arb_outstanding), 4);
    tick();
    bus.buf_arb_rd_resp_val  = 1'b1;
    bus.buf_arb_rd_resp_data = 32'h60;
    resp_q.push_back({2'b01, 32'h60});
    mid();
    chk("t4_nobypass_req_val", 32'(bus.arb_buf_rd_req_val), 0);
    chk("t4_nobypass_src_rdy", 32'(bus.arb_src_rd_req_rdy), 0);
    tick();
    bus.buf_arb_rd_resp_val = 1'b0;
    req_q.push_back({2'b01, 32'h40});
    mid();
    chk("t4_reissue_out", 32'(bus.arb_outstanding), 3);
    chk("t4_reissue_val", 32'(bus.arb_buf_rd_req_val), 1);
    tick();
    bus.src_arb_rd_req_val = 2'b00;
    for (int k = 0; k < 4; k++) begin
      bus.buf_arb_rd_resp_val  = 1'b1;
      bus.buf_arb_rd_resp_data = 32'h61 + 32'(k);
      resp_q.push_back({2'b01, 32'h61 + 32'(k)});
      mid();
      chk("t4_drain_out", 32'(bus.arb_outstanding), 32'(4 - k));
      tick();
    end
    bus.buf_arb_rd_resp_val = 1'b0;
    mid();
    chk("t4_empty_out", 32'(bus.arb_outstanding), 0);
    tick();
    // head-of-line blocking: tag 1 at head, source 1 not ready
    bus.src_arb_rd_req_val  = 2'b10;
    bus.src_arb_rd_req_addr = {8'h71, 8'h70};
    req_q.push_back({2'b10, 32'h71});
    mid();
    tick();
    bus.src_arb_rd_req_val = 2'b01;
    req_q.push_back({2'b01, 32'h70});
    mid();
    tick();
    bus.src_arb_rd_req_val   = 2'b00;
    bus.src_arb_rd_resp_rdy  = 2'b01;
    bus.buf_arb_rd_resp_val  = 1'b1;
    bus.buf_arb_rd_resp_data = 32'h81;
    for (int k = 0; k < 2; k++) begin
      mid();
      chk("t5_hol_rdy", 32'(bus.arb_buf_rd_resp_rdy), 0);
      chk("t5_hol_val", 32'(bus.arb_src_rd_resp_val), 32'h2);
      chk("t5_hol_out", 32'(bus.arb_outstanding), 2);
      tick();
    end
    bus.src_arb_rd_resp_rdy = 2'b11;
    resp_q.push_back({2'b10, 32'h81});
    mid();
    tick();
    bus.buf_arb_rd_resp_data = 32'h80;
    resp_q.push_back({2'b01, 32'h80});
    mid();
    tick();
    bus.buf_arb_rd_resp_val = 1'b0;
    mid();
    chk("t5_out", 32'(bus.arb_outstanding), 0);
    tick();
    // reset with 3 outstanding; rr_ptr is 1 beforehand
    bus.src_arb_rd_req_val  = 2'b01;
    bus.src_arb_rd_req_addr = {8'h00, 8'h90};
    for (int k = 0; k < 3; k++) begin
      req_q.push_back({2'b01, 32'h90});
      mid();
      tick();
    end
    bus.src_arb_rd_req_val = 2'b00;
    rst = 1'b1;
    mid();
    chk("t6_pre_out", 32'(bus.arb_outstanding), 3);
    tick();
    bus.buf_arb_rd_resp_val  = 1'b1;
    bus.buf_arb_rd_resp_data = 32'hEE;
    mid();
    chk("t6_out", 32'(bus.arb_outstanding), 0);
    chk("t6_req_val", 32'(bus.arb_buf_rd_req_val), 0);
    chk("t6_src_rdy", 32'(bus.arb_src_rd_req_rdy), 0);
    chk("t6_resp_val", 32'(bus.arb_src_rd_resp_val), 0);
    chk("t6_resp_rdy", 32'(bus.arb_buf_rd_resp_rdy), 0);
    tick();
    rst = 1'b0;
    bus.buf_arb_rd_resp_val = 1'b0;
    bus.src_arb_rd_req_val  = 2'b11;
    bus.src_arb_rd_req_addr = {8'hB1, 8'hB0};
    req_q.push_back({2'b01, 32'hB0});
    mid();
    tick();
    bus.src_arb_rd_req_val   = 2'b00;
    bus.buf_arb_rd_resp_val  = 1'b1;
    bus.buf_arb_rd_resp_data = 32'hC0;
    resp_q.push_back({2'b01, 32'hC0});
    mid();
    tick();
    bus.buf_arb_rd_resp_val = 1'b0;
    mid();
    chk("t6_final_out", 32'(bus.arb_outstanding), 0);
    chk("req_q_empty", 32'(req_q.size()), 0);
    chk("resp_q_empty", 32'(resp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
